// File: rtl/bomb_timer_ctrl_if.sv
// Signal bundle between the bomb fuse controller, game logic and the BCD fuse counter.
// master = game logic / fuse-counter side, slave = bomb_timer_ctrl.
interface bomb_timer_ctrl_if;
  logic       place_req;
  logic       force_det;
  logic       pause;
  logic       cnt_tc;
  logic       cnt_loadN;
  logic       cnt_en1;
  logic       cnt_en2;
  logic       place_ack;
  logic       bomb_active;
  logic       exploding;
  logic       explode_start;
  logic [1:0] state;

  modport master (
    output place_req, force_det, pause, cnt_tc,
    input  cnt_loadN, cnt_en1, cnt_en2, place_ack, bomb_active, exploding,
           explode_start, state
  );

  modport slave (
    input  place_req, force_det, pause, cnt_tc,
    output cnt_loadN, cnt_en1, cnt_en2, place_ack, bomb_active, exploding,
           explode_start, state
  );
endinterface

// File: rtl/bomb_timer_ctrl.sv
// Bomb fuse sequencer: IDLE -> ARM -> COUNT -> BLAST, driving a BCD down counter.
// Define BOMB_FORCE_DET_EN to let force_det cut the fuse short during COUNT.
module bomb_timer_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BLAST_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  bomb_timer_ctrl_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLAST_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLAST_LAST = BW'(BLAST_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    BLAST = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [BW-1:0] blast_reg, blast_next;
  logic          blast_seen_reg;

  logic det;
  logic wrap;
  logic exit_count;
  logic load_n;
  logic en1;
  logic en2;
  logic ack;

`ifdef BOMB_FORCE_DET_EN
  assign det = bus.force_det;
`else
  logic unused_force_det;
  assign unused_force_det = bus.force_det;
  assign det = 1'b0;
`endif

  assign wrap       = (pre_reg == PRE_LAST) && !bus.pause;
  assign exit_count = (state_reg == COUNT) && !bus.pause && (bus.cnt_tc || det);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pre_reg        <= '0;
      blast_reg      <= '0;
      blast_seen_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pre_reg        <= pre_next;
      blast_reg      <= blast_next;
      blast_seen_reg <= (state_reg == BLAST);
    end
  end

  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    blast_next = blast_reg;
    load_n     = 1'b1;
    en1        = 1'b0;
    en2        = 1'b0;
    ack        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.place_req) state_next = ARM;
      end
      ARM: begin
        load_n     = 1'b0;
        ack        = 1'b1;
        pre_next   = '0;
        state_next = COUNT;
      end
      COUNT: begin
        en2 = !bus.pause;
        // Exit suppresses the strobe so the counter never wraps 00 -> 99.
        if (exit_count) begin
          state_next = BLAST;
          pre_next   = '0;
        end else if (!bus.pause) begin
          en1      = wrap;
          pre_next = wrap ? '0 : pre_reg + PW'(1);
        end
      end
      BLAST: begin
        if (!bus.pause) begin
          pre_next = wrap ? '0 : pre_reg + PW'(1);
          if (wrap) begin
            if (blast_reg == BLAST_LAST) begin
              state_next = IDLE;
              blast_next = '0;
            end else begin
              blast_next = blast_reg + BW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cnt_loadN     = load_n;
  assign bus.cnt_en1       = en1;
  assign bus.cnt_en2       = en2;
  assign bus.place_ack     = ack;
  assign bus.bomb_active   = (state_reg == ARM) || (state_reg == COUNT);
  assign bus.exploding     = (state_reg == BLAST);
  assign bus.explode_start = (state_reg == BLAST) && !blast_seen_reg;
  assign bus.state         = state_reg;
endmodule

// File: tb/tb_bomb_timer_ctrl.sv
// Self-checking bench for bomb_timer_ctrl with a behavioural BCD fuse counter model.
// Honors BOMB_FORCE_DET_EN when choosing chain-reaction expectations.
module tb_bomb_timer_ctrl;
  localparam int TD = 4;
  localparam int BT = 2;
`ifdef BOMB_FORCE_DET_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif
  localparam bit O = 1'b0;
  localparam bit I = 1'b1;
  localparam logic [1:0] SI = 2'd0, SA = 2'd1, SC = 2'd2, SB = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bomb_timer_ctrl_if bus();

  bomb_timer_ctrl #(.TICK_DIV(TD), .BLAST_TICKS(BT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Fuse counter: decimal value stands in for the two BCD digits.
  int fuse     = 99;
  int load_val = 3;
  bit tc_ovr   = 1'b0;
  bit tc_val   = 1'b0;
  always @(posedge clk) begin
    if (!bus.cnt_loadN) fuse <= load_val;
    else if (bus.cnt_en1 && bus.cnt_en2) fuse <= (fuse == 0) ? 99 : fuse - 1;
  end
  assign bus.cnt_tc = tc_ovr ? tc_val : (fuse == 0);

  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] ev(logic [1:0] st, bit ld, bit e1, bit e2, bit ak, bit xs);
    return {st, ld, e1, e2, ak, (st == SA || st == SC), (st == SB), xs};
  endfunction

  function automatic logic [8:0] got();
    return {bus.state, bus.cnt_loadN, bus.cnt_en1, bus.cnt_en2, bus.place_ack,
            bus.bomb_active, bus.exploding, bus.explode_start};
  endfunction

  task automatic check(input string nm, input logic [8:0] g, input logic [8:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got {st,ld,en1,en2,ack,act,expl,xs}=%b expected %b at %0t", nm, g, e, $time);
    end
  endtask

  task automatic check_int(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, g, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         n;
    bit         pr, pa;
    logic [1:0] st;
    bit         ld, e1, e2, ak, xs;
    int         fz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, bit pr, bit pa, logic [1:0] st,
                              bit ld, bit e1, bit e2, bit ak, bit xs, int fz);
    vec_t v;
    v.n = n; v.pr = pr; v.pa = pa; v.st = st;
    v.ld = ld; v.e1 = e1; v.e2 = e2; v.ak = ak; v.xs = xs; v.fz = fz;
    return v;
  endfunction

  // Behavioural model: phase plus elapsed unpaused cycles in the timed phase.
  int  ph = 0, run = 0, age = 0;
  bit  m_exit, m_en1;

  initial begin
    int c, hit, xs_cnt, acks, first_ack, second_ack;
    reset = 1'b1;
    bus.place_req = 1'b0;
    bus.force_det = 1'b0;
    bus.pause     = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_state", got(), ev(SI, I, O, O, O, O));
    tick();
    reset = 1'b0;

    // Normal countdown, then the same bomb with a 10-cycle pause after the first strobe.
    tbl.push_back(mk(1, I, O, SI, I, O, O, O, O, -1));
    tbl.push_back(mk(1, O, O, SA, O, O, O, I, O, -1));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 3));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 3));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 2));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 2));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 1));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 1));
    tbl.push_back(mk(1, O, O, SC, I, O, I, O, O, 0));
    tbl.push_back(mk(1, O, O, SB, I, O, O, O, I, 0));
    tbl.push_back(mk(7, O, O, SB, I, O, O, O, O, 0));
    tbl.push_back(mk(1, O, O, SI, I, O, O, O, O, 0));
    tbl.push_back(mk(1, I, O, SI, I, O, O, O, O, -1));
    tbl.push_back(mk(1, O, O, SA, O, O, O, I, O, -1));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 3));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 3));
    tbl.push_back(mk(10, O, I, SC, I, O, O, O, O, 2));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 2));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 2));
    tbl.push_back(mk(3, O, O, SC, I, O, I, O, O, 1));
    tbl.push_back(mk(1, O, O, SC, I, I, I, O, O, 1));
    tbl.push_back(mk(1, O, O, SC, I, O, I, O, O, 0));
    tbl.push_back(mk(1, O, O, SB, I, O, O, O, I, 0));
    tbl.push_back(mk(7, O, O, SB, I, O, O, O, O, 0));
    tbl.push_back(mk(1, O, O, SI, I, O, O, O, O, 0));

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        bus.place_req = tbl[r].pr;
        bus.pause     = tbl[r].pa;
        bus.force_det = 1'b0;
        @(negedge clk);
        check($sformatf("tbl%0d", r), got(),
              ev(tbl[r].st, tbl[r].ld, tbl[r].e1, tbl[r].e2, tbl[r].ak, tbl[r].xs));
        if (tbl[r].fz >= 0) check_int($sformatf("tbl%0d_fuse", r), fuse, tbl[r].fz);
        tick();
      end
      $display("row %0d: %0d cycles state=%0d", r, tbl[r].n, tbl[r].st);
    end
    bus.place_req = 1'b0;
    bus.pause     = 1'b0;

    // Reset held for two cycles in the middle of COUNT.
    bus.place_req = 1'b1;
    tick();
    bus.place_req = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_hold1", got(), ev(SI, I, O, O, O, O));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_hold2", got(), ev(SI, I, O, O, O, O));
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst_after", got(), ev(SI, I, O, O, O, O));
      tick();
    end
    $display("reset mid-COUNT sequence done");

    // Chain reaction: force_det asserted once the counter reads 02.
    bus.place_req = 1'b1;
    tick();
    bus.place_req = 1'b0;
    tick();
    hit = -1;
    for (c = 0; c < 40; c++) begin
      bus.force_det = (c >= 4);
      @(negedge clk);
      if (bus.exploding) begin
        hit = c;
        break;
      end
      tick();
    end
    check_int("chain_blast_cycle", hit, DET ? 5 : 13);
    check_int("chain_fuse_entry", fuse, DET ? 2 : 0);
    tick();
    bus.force_det = 1'b0;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.state == SI) begin
        hit = 1;
        break;
      end
      tick();
    end
    check_int("chain_idle_reached", hit, 1);
    check_int("chain_fuse_frozen", fuse, DET ? 2 : 0);
    tick();
    $display("chain reaction sequence done (force_det enabled=%0d)", DET);

    // Terminal count coinciding with a prescaler wrap.
    bus.place_req = 1'b1;
    tick();
    bus.place_req = 1'b0;
    tick();
    repeat (3) tick();
    tc_ovr = 1'b1;
    tc_val = 1'b1;
    @(negedge clk);
    check("simul_tc_tick", got(), ev(SC, I, O, I, O, O));
    tick();
    tc_ovr = 1'b0;
    xs_cnt = 0;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.explode_start) xs_cnt++;
      if (bus.state == SI) begin
        hit = 1;
        break;
      end
      tick();
    end
    check_int("simul_idle_reached", hit, 1);
    check_int("simul_xs_count", xs_cnt, 1);
    check_int("simul_fuse_held", fuse, 3);
    tick();
    $display("simultaneous tc/tick sequence done");

    // Back-to-back: place_req held through BLAST.
    acks = 0;
    first_ack = -1;
    second_ack = -1;
    for (int i = 0; i < 60; i++) begin
      bus.place_req = (i < 26);
      @(negedge clk);
      if (bus.place_ack) begin
        acks++;
        if (first_ack < 0) first_ack = i;
        else second_ack = i;
      end
      tick();
    end
    bus.place_req = 1'b0;
    check_int("b2b_ack_count", acks, 2);
    check_int("b2b_first_arm", first_ack, 1);
    check_int("b2b_second_arm", second_ack, 24);
    $display("back-to-back sequence done");

    // Randomized run against the behavioural model.
    ph = 0; run = 0; age = 0;
    for (int i = 0; i < 800; i++) begin
      reset         = (i == 0) || ($urandom_range(99) == 0);
      bus.place_req = ($urandom_range(9) < 3);
      bus.pause     = ($urandom_range(3) == 0);
      bus.force_det = ($urandom_range(19) == 0);
      load_val      = int'($urandom_range(3));
      @(negedge clk);
      m_exit = (ph == 2) && !bus.pause && (bus.cnt_tc || (DET && bus.force_det));
      m_en1  = (ph == 2) && !bus.pause && !m_exit && (((run + 1) % TD) == 0);
      check($sformatf("rand%0d", i), got(),
            ev(2'(ph), (ph != 1), m_en1, (ph == 2) && !bus.pause, (ph == 1), (ph == 3) && (age == 0)));
      if (reset) begin
        ph = 0; run = 0; age = 0;
      end else begin
        case (ph)
          0: if (bus.place_req) ph = 1;
          1: begin ph = 2; run = 0; end
          2: begin
            if (m_exit) begin ph = 3; run = 0; age = 0; end
            else if (!bus.pause) run++;
          end
          default: begin
            age++;
            if (!bus.pause) begin
              run++;
              if (run == BT * TD) begin ph = 0; run = 0; end
            end
          end
        endcase
      end
      tick();
    end
    reset = 1'b0;
    $display("random run of 800 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bomb_timer_ctrl.md
# bomb_timer_ctrl

Sequencing controller for one BCD bomb-fuse down counter in the Bomberman VGA datapath. It accepts a bomb-placement request and loads the counter. It then generates the one-second count strobes and the run/pause enable. When the counter reaches terminal count, or a chain-reaction detonation arrives, it drives a timed blast phase and returns to idle. It sits between the player/game logic and the fuse counter, which it drives through that counter's loadN/enable1/enable2/tc pins.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clocks per count tick; minimum 2.
- BLAST_TICKS, 2: blast duration in ticks; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- place_req  in  1  level; request to arm a bomb.
- force_det  in  1  level; chain-reaction hit, detonate now.
- pause  in  1  level; freeze all timing.
- cnt_tc  in  1  terminal count from fuse counter (count == 00).
- cnt_loadN  out  1  active-low load to fuse counter.
- cnt_en1  out  1  one-clock count strobe to fuse counter.
- cnt_en2  out  1  run enable to fuse counter.
- place_ack  out  1  one-clock pulse; bomb accepted.
- bomb_active  out  1  high in ARM and COUNT.
- exploding  out  1  high in BLAST.
- explode_start  out  1  one-clock pulse on the first BLAST cycle.
- state  out  2  IDLE=0, ARM=1, COUNT=2, BLAST=3.

## Operation
- State, prescaler (width $clog2(TICK_DIV)) and blast tick counter (width $clog2(BLAST_TICKS+1)) are registered.
- Reset values:
  - state=IDLE, prescaler=0, blast count=0.
  - cnt_loadN=1, cnt_en1=0, cnt_en2=0.
  - place_ack=0, bomb_active=0, exploding=0, explode_start=0.
- IDLE:
  - Outputs idle.
  - place_req=1 → ARM.
  - force_det and pause are ignored.
- ARM (exactly one cycle):
  - cnt_loadN=0, place_ack=1, prescaler cleared → COUNT.
  - pause does not block ARM.
- COUNT:
  - cnt_en2 = !pause, decoded combinationally from state and pause.
  - When !pause, the prescaler increments. At TICK_DIV-1 it wraps to 0 and cnt_en1=1 for that cycle.
  - When pause=1, the prescaler holds and cnt_en1=0.
  - Exit → BLAST when !pause and (cnt_tc=1 or force_det=1).
  - On the exit cycle cnt_en1 is forced 0 even if the prescaler wraps, so the counter never wraps 00→99.
  - place_req is ignored: one bomb per controller.
- BLAST:
  - exploding=1; explode_start=1 in the first BLAST cycle only.
  - Prescaler restarts from 0 on entry. Each wrap while !pause increments the blast count.
  - When the count reaches BLAST_TICKS → IDLE, with prescaler and blast count cleared.
  - pause freezes the prescaler; place_req and force_det are ignored.
- Simultaneous events in COUNT: cnt_tc and force_det together produce one BLAST entry.
- reset outranks everything and forces IDLE on the next edge from any state.
- state encodes the current FSM state directly; bomb_active and exploding are decoded from state.

## Timing
- place_req sampled high at edge k in IDLE:
  - ARM during cycle k+1, with cnt_loadN=0 and place_ack=1.
  - COUNT from k+2.
- First cnt_en1 occurs TICK_DIV cycles after COUNT entry, counting unpaused cycles only. Strobes then repeat every TICK_DIV unpaused cycles.
- Fuse load value D (BCD) gives BLAST entry one cycle after the cycle in which cnt_tc is sampled high. Total ARM→BLAST latency is D·TICK_DIV + 2 cycles when unpaused.
- force_det sampled at edge m in COUNT (unpaused) → exploding=1 in cycle m+1.
- BLAST lasts BLAST_TICKS·TICK_DIV unpaused cycles, then IDLE.
- A new place_req is accepted on the first IDLE cycle, with no dead cycle after BLAST.
- A loaded value of 00 gives cnt_tc=1 at COUNT entry, so the controller enters BLAST after one COUNT cycle.

## Configuration
- BOMB_FORCE_DET_EN defined: force_det triggers COUNT→BLAST as described.
- BOMB_FORCE_DET_EN undefined:
  - force_det is ignored everywhere; the port remains, unused.
  - BLAST is entered only via cnt_tc.

## Test plan
All scenarios use TICK_DIV=4, BLAST_TICKS=2, and the fuse counter loaded with 03.

- **Reset:** reset held 2 cycles mid-COUNT → state=0, all outputs at reset values next cycle; cnt_en1 stays 0 thereafter.
- **Normal countdown:**
  - Stimulus: place_req pulse in IDLE.
  - place_ack=1 and cnt_loadN=0 for one cycle.
  - Three cnt_en1 strobes, 4 cycles apart; counter reads 02, 01, 00.
  - explode_start=1 one cycle after tc; exploding high for 8 cycles; then state=0.
- **Pause:**
  - Stimulus: pause=1 for 10 cycles after the first strobe.
  - cnt_en2=0, no strobes, prescaler held.
  - BLAST entry delayed exactly 10 cycles versus the normal-countdown scenario.
- **Chain reaction:**
  - Stimulus: force_det=1 at counter value 02.
  - With BOMB_FORCE_DET_EN: exploding next cycle, counter frozen at 02.
  - Without the macro: no effect; normal tc timing.
- **Simultaneous tc and tick:** at count 00 with prescaler=3 → cnt_en1=0, counter stays 00, single explode_start.
- **Back-to-back:**
  - Stimulus: place_req held high through BLAST.
  - Ignored during COUNT and BLAST; second ARM on the first IDLE cycle; place_ack pulses exactly twice.
